vc_output_allocator: RTL and testbench

Sequential per-output-VC allocator that owns the occupancy state consumed by the per-VC priority chain. For one (output port, VC) pair it arbitrates round-robin among input ports whose head flit routes to it, holds ownership wormhole-style until the tail flit passes, and gates each flit transfer on downstream credits. It sits in the router between the route-lookup/priority logic and the crossbar, one instance per output port per VC.

---
 rtl/vc_output_allocator.sv | 143 ++++++++++++++
 tb/tb_vc_output_allocator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_allocator.sv
// vc_output_allocator
//   Per (output port, VC) allocator. Arbitrates round-robin among input ports
//   whose head flit targets this output VC. It holds ownership until the tail
//   flit has been forwarded, and gates every flit on downstream credits.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   req_valid[P]    input p has a flit for this output VC
//   req_tail[P]     input p's current flit is a tail
//   credit_return   one-cycle pulse: downstream freed one slot
//   grant[P]        registered one-hot owner, zero when idle
//   fwd             combinational: owner's flit moves this cycle
//   fwd_port        owner index
//   occupied_o      {busy, owner index}
//   credits_o       current downstream credit count
//   err_credit      sticky: credit returned while already full
module vc_output_allocator #(
  parameter int unsigned PORTS     = 5,
  parameter int unsigned LOG_PORTS = 4,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CRED_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORTS-1:0]     req_valid,
  input  logic [PORTS-1:0]     req_tail,
  input  logic                 credit_return,
  output logic [PORTS-1:0]     grant,
  output logic                 fwd,
  output logic [LOG_PORTS-1:0] fwd_port,
  output logic [LOG_PORTS:0]   occupied_o,
  output logic [CRED_W-1:0]    credits_o,
  output logic                 err_credit
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CRED_W-1:0]    FULL     = CRED_W'(BUF_DEPTH);
  localparam logic [LOG_PORTS-1:0] LAST_IDX = LOG_PORTS'(PORTS - 1);

  state_t               state, state_next;
  logic [PORTS-1:0]     grant_q, grant_next;
  logic [LOG_PORTS-1:0] owner, owner_next;
  logic [LOG_PORTS-1:0] rr_ptr, rr_next;
  logic [LOG_PORTS-1:0] winner;
  logic                 found;
  logic [CRED_W-1:0]    credits, credits_next;
  logic                 err, err_next;
  logic                 owner_req, owner_tail;

  // The grant register is one-hot on the owner, so masking with it selects
  // the owner's request and tail bits without a variable-width index.
  assign owner_req  = |(req_valid & grant_q);
  assign owner_tail = |(req_tail & grant_q);

  assign fwd = (state == BUSY) && owner_req && (credits != '0);

  // Round-robin search: first the ports at or above rr_ptr, then wrap to the
  // ports below it.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (!found && req_valid[p] && (LOG_PORTS'(p) >= rr_ptr)) begin
        winner = LOG_PORTS'(p);
        found  = 1'b1;
      end
    end
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (!found && req_valid[p] && (LOG_PORTS'(p) < rr_ptr)) begin
        winner = LOG_PORTS'(p);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant_q;
    owner_next   = owner;
    rr_next      = rr_ptr;
    credits_next = credits;
    err_next     = err;

    case (state)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          owner_next = winner;
          grant_next = PORTS'(1) << winner;
          rr_next    = (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
      end
      BUSY: begin
        if (fwd && owner_tail) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    case ({fwd, credit_return})
      2'b10: credits_next = credits - 1'b1;
      2'b01: begin
        if (credits == FULL) begin
          err_next = 1'b1;
        end else begin
          credits_next = credits + 1'b1;
        end
      end
      default: credits_next = credits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      credits <= FULL;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
      owner   <= owner_next;
      rr_ptr  <= rr_next;
      credits <= credits_next;
      err     <= err_next;
    end
  end

  assign grant      = grant_q;
  assign fwd_port   = owner;
  assign occupied_o = {state == BUSY, owner};
  assign credits_o  = credits;
  assign err_credit = err;

endmodule

// File: tb/tb_vc_output_allocator.sv
// tb_vc_output_allocator
//   Directed-vector bench for vc_output_allocator. Inputs are driven 1 time
//   unit after the rising edge. The combinational fwd is checked before the
//   next edge, and registered outputs are checked 1 time unit after it.
module tb_vc_output_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req_valid;
  logic [4:0] req_tail;
  logic       credit_return;
  logic [4:0] grant;
  logic       fwd;
  logic [3:0] fwd_port;
  logic [4:0] occupied_o;
  logic [2:0] credits_o;
  logic       err_credit;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  vc_output_allocator #(
    .PORTS(5),
    .LOG_PORTS(4),
    .BUF_DEPTH(4),
    .CRED_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_tail(req_tail),
    .credit_return(credit_return),
    .grant(grant),
    .fwd(fwd),
    .fwd_port(fwd_port),
    .occupied_o(occupied_o),
    .credits_o(credits_o),
    .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [4:0] t, input logic cr);
    req_valid     = v;
    req_tail      = t;
    credit_return = cr;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'b0, 5'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  int unsigned owners [5] = '{0, 2, 4, 0, 2};

  initial begin
    // Reset values and the first grant
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_occ", occupied_o, 0);
    check("rst_fwd", fwd, 0);
    check("rst_fwd_port", fwd_port, 0);
    check("rst_credits", credits_o, 4);
    check("rst_err", err_credit, 0);

    drive(5'b00100, 5'b00000, 1'b0);
    check("idle_fwd", fwd, 0);
    step();
    check("g1_grant", grant, 5'b00100);
    check("g1_occ", occupied_o, 5'b10010);
    check("g1_fwd_port", fwd_port, 2);
    drive(5'b00100, 5'b00100, 1'b0);
    check("g1_fwd", fwd, 1);
    step();
    check("g1_rel_grant", grant, 0);
    check("g1_rel_busy", occupied_o[4], 0);
    check("g1_rel_cred", credits_o, 3);

    // rr_ptr is now 3: all-port requests go 3, 4, then wrap to 0
    drive(5'b11111, 5'b11111, 1'b1);
    step();
    check("rr3_grant", grant, 5'b01000);
    check("rr3_cred", credits_o, 4);
    drive(5'b11111, 5'b11111, 1'b1);
    check("rr3_fwd", fwd, 1);
    step();
    check("rr3_cred_same", credits_o, 4);
    drive(5'b11111, 5'b11111, 1'b0);
    step();
    check("rr4_grant", grant, 5'b10000);
    drive(5'b11111, 5'b11111, 1'b1);
    step();
    drive(5'b11111, 5'b11111, 1'b0);
    step();
    check("rr0_grant", grant, 5'b00001);
    check("rr_err_clean", err_credit, 0);

    // Ports 0, 2 and 4 with single-flit packets, a credit returned on every fwd
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(5'b10101, 5'b10101, 1'b0);
      check("rr_idle_fwd", fwd, 0);
      step();
      check("rr_owner", grant, 32'd1 << owners[k]);
      drive(5'b10101, 5'b10101, 1'b1);
      check("rr_busy_fwd", fwd, 1);
      step();
      check("rr_gap_grant", grant, 0);
      check("rr_credits", credits_o, 4);
    end

    // Credit exhaustion: port 1 sends 3 flits, then a 4-flit packet stalls
    do_reset();
    drive(5'b00010, 5'b00000, 1'b0);
    step();
    check("c_grant", grant, 5'b00010);
    for (int k = 0; k < 3; k++) begin
      drive(5'b00010, (k == 2) ? 5'b00010 : 5'b00000, 1'b0);
      check("c_fwd", fwd, 1);
      step();
      check("c_credits", credits_o, 3 - k);
    end
    check("c_release", grant, 0);
    drive(5'b00010, 5'b00000, 1'b0);
    step();
    check("c2_grant", grant, 5'b00010);
    drive(5'b00010, 5'b00000, 1'b0);
    check("c2_f1_fwd", fwd, 1);
    step();
    check("c2_cred0", credits_o, 0);
    drive(5'b00010, 5'b00000, 1'b0);
    check("c2_stall_fwd", fwd, 0);
    step();
    check("c2_stall_grant", grant, 5'b00010);
    drive(5'b00010, 5'b00000, 1'b1);
    check("c2_cr_at0_fwd", fwd, 0);
    step();
    check("c2_cred1", credits_o, 1);
    drive(5'b00010, 5'b00000, 1'b0);
    check("c2_f2_fwd", fwd, 1);
    step();
    check("c2_cred0b", credits_o, 0);
    drive(5'b00010, 5'b00000, 1'b1);
    check("c2_stall2_fwd", fwd, 0);
    step();
    drive(5'b00010, 5'b00000, 1'b1);
    check("c2_f3_fwd", fwd, 1);
    step();
    check("c2_cred_keep", credits_o, 1);
    drive(5'b00010, 5'b00010, 1'b0);
    check("c2_f4_fwd", fwd, 1);
    step();
    check("c2_release", grant, 0);
    check("c2_cred_end", credits_o, 0);

    // Owner bubble while port 3 is requesting
    do_reset();
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    check("b_grant", grant, 5'b00001);
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(5'b01000, 5'b00000, 1'b0);
      check("b_gap_fwd", fwd, 0);
      step();
      check("b_gap_grant", grant, 5'b00001);
      check("b_gap_cred", credits_o, 3);
    end
    drive(5'b01001, 5'b00001, 1'b0);
    check("b_tail_fwd", fwd, 1);
    step();
    check("b_release", grant, 0);
    drive(5'b01000, 5'b00000, 1'b0);
    step();
    check("b_p3_grant", grant, 5'b01000);
    check("b_p3_occ", occupied_o, 5'b10011);

    // Simultaneous fwd/credit and credit overflow
    do_reset();
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    check("o_cred2", credits_o, 2);
    drive(5'b00001, 5'b00000, 1'b1);
    check("o_both_fwd", fwd, 1);
    step();
    check("o_both_cred", credits_o, 2);
    drive(5'b00001, 5'b00001, 1'b1);
    step();
    check("o_tail_cred", credits_o, 2);
    drive(5'b00000, 5'b00000, 1'b1);
    step();
    drive(5'b00000, 5'b00000, 1'b1);
    step();
    check("o_cred_full", credits_o, 4);
    check("o_err_pre", err_credit, 0);
    drive(5'b00000, 5'b00000, 1'b1);
    step();
    check("o_cred_sat", credits_o, 4);
    check("o_err_set", err_credit, 1);
    drive(5'b00000, 5'b00000, 1'b0);
    step();
    check("o_err_sticky", err_credit, 1);

    // Reset in the middle of a packet with one credit left
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(5'b00001, 5'b00000, 1'b0);
      step();
    end
    check("r_cred1", credits_o, 1);
    check("r_grant_pre", grant, 5'b00001);
    reset = 1'b1;
    drive(5'b00001, 5'b00000, 1'b0);
    step();
    check("r_grant", grant, 0);
    check("r_occ", occupied_o, 0);
    check("r_cred", credits_o, 4);
    check("r_err", err_credit, 0);
    check("r_fwd", fwd, 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
